// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bundle from the VGA timing generator to the pixel renderers
//   o_pix_stb      pixel strobe, one clk_in cycle every CLK_DIV cycles
//   o_hs/o_vs      active-low sync pins
//   o_active       current pixel lies in the visible area
//   o_x/o_y        clamped raster position
//   o_line_start   one-cycle pulse when the line wraps to column 0
//   o_frame_start  one-cycle pulse when the frame wraps to (0,0)
//   o_animate      one-cycle pulse on entering vertical blanking
interface vga_timing_gen_if;
    logic       o_pix_stb;
    logic       o_hs;
    logic       o_vs;
    logic       o_active;
    logic [9:0] o_x;
    logic [8:0] o_y;
    logic       o_line_start;
    logic       o_frame_start;
    logic       o_animate;
    modport master (
        output o_pix_stb, o_hs, o_vs, o_active, o_x, o_y,
        output o_line_start, o_frame_start, o_animate
    );
    modport slave (
        input o_pix_stb, o_hs, o_vs, o_active, o_x, o_y,
        input o_line_start, o_frame_start, o_animate
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing, sync pins and line/frame event pulses
//   clk_in  board clock, the only clock in the block
//   i_rst   asynchronous active-low reset
//   vga     raster bundle driven out through the master modport
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                    clk_in,
    input  logic                    i_rst,
    vga_timing_gen_if.master        vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

    logic [DW-1:0] r_div;
    logic [9:0]    r_h;
    logic [9:0]    r_v;
    logic          w_tick;
    logic          w_h_wrap;
    logic          w_line0;
    logic [9:0]    w_h_next;
    logic [9:0]    w_v_next;

    // Outputs are decoded from the next counter values so they move on the
    // same edge as the counters instead of lagging a pixel behind.
    always_comb begin
        w_tick   = r_div == DW'(CLK_DIV - 1);
        w_h_wrap = r_h == H_LAST;
        w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next = !w_h_wrap ? r_v : (r_v == V_LAST ? 10'd0 : r_v + 10'd1);
        w_line0  = w_tick && w_h_next == 10'd0;
    end

    // Counters reset to the last position so the first strobe wraps to (0,0)
    // and every visible frame is preceded by a frame_start.
    always_ff @(posedge clk_in or negedge i_rst) begin
        if (!i_rst) begin
            r_div             <= '0;
            r_h               <= H_LAST;
            r_v               <= V_LAST;
            vga.o_pix_stb     <= 1'b0;
            vga.o_hs          <= 1'b1;
            vga.o_vs          <= 1'b1;
            vga.o_active      <= 1'b0;
            vga.o_x           <= '0;
            vga.o_y           <= '0;
            vga.o_line_start  <= 1'b0;
            vga.o_frame_start <= 1'b0;
            vga.o_animate     <= 1'b0;
        end else begin
            r_div             <= w_tick ? '0 : r_div + 1'b1;
            vga.o_pix_stb     <= w_tick;
            vga.o_line_start  <= w_line0;
            vga.o_frame_start <= w_line0 && w_v_next == 10'd0;
            vga.o_animate     <= w_line0 && w_v_next == V_ACT;
            if (w_tick) begin
                r_h          <= w_h_next;
                r_v          <= w_v_next;
                vga.o_hs     <= !(w_h_next >= HS_LO && w_h_next < HS_HI);
                vga.o_vs     <= !(w_v_next >= VS_LO && w_v_next < VS_HI);
                vga.o_active <= w_h_next < H_ACT && w_v_next < V_ACT;
                vga.o_x      <= w_h_next < H_ACT ? w_h_next : 10'(H_ACTIVE - 1);
                vga.o_y      <= w_v_next < V_ACT ? w_v_next[8:0] : 9'(V_ACTIVE - 1);
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench over full-size and shrunken raster geometries
module tb_vga_timing_gen;
    logic clk_in = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;

    always #5 clk_in = ~clk_in;

    localparam logic [24:0] RSTV = {1'b1, 1'b1, 1'b0, 10'd0, 9'd0, 3'b000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    endtask

    // Expected {hs,vs,active,x,y,line_start,frame_start,animate} for the k-th strobe after reset release.
    function automatic logic [24:0] model(input int k, input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb);
        int ht, vt, c, h, v;
        logic hs, vs, act;
        logic [9:0] x;
        logic [8:0] y;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        c   = k % (ht * vt);
        h   = c % ht;
        v   = c / ht;
        hs  = !(h >= ha + hf && h < ha + hf + hsw);
        vs  = !(v >= va + vf && v < va + vf + vsw);
        act = h < ha && v < va;
        x   = 10'(h < ha ? h : ha - 1);
        y   = 9'(v < va ? v : va - 1);
        return {hs, vs, act, x, y, h == 0, h == 0 && v == 0, h == 0 && v == va};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int CD = g == 2 ? 1 : 2;
        localparam int HA = g == 0 ? 640 : 8;
        localparam int HF = g == 0 ? 16 : 2;
        localparam int HS = g == 0 ? 96 : 3;
        localparam int HB = g == 0 ? 48 : 2;
        localparam int VA = g == 0 ? 480 : 6;
        localparam int VF = g == 0 ? 10 : 2;
        localparam int VS = 2;
        localparam int VB = g == 0 ? 33 : 3;
        localparam int N1 = g == 0 ? 1201 : 469;
        localparam int N2 = g == 0 ? 1700 : 395;

        logic        rst;
        logic [24:0] q[$];
        logic [24:0] last;
        logic [24:0] e;
        logic [25:0] a;
        int          since;
        int          idx;

        vga_timing_gen_if u_if ();
        vga_timing_gen #(
            .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
        ) u_dut (
            .clk_in(clk_in),
            .i_rst (rst),
            .vga   (u_if)
        );

        always_comb a = {u_if.o_pix_stb, u_if.o_hs, u_if.o_vs, u_if.o_active, u_if.o_x, u_if.o_y,
                         u_if.o_line_start, u_if.o_frame_start, u_if.o_animate};

        always @(negedge clk_in) begin
            if (!rst) begin
                since = 0;
                idx   = 0;
                last  = RSTV;
                chk($sformatf("i%0d reset_vals", g), 32'(a), 32'({1'b0, RSTV}));
            end else begin
                since++;
                if (a[25]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("i%0d unexpected_stb", g), 32'(a[25]), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("i%0d strobe k=%0d", g, idx), 32'(a), 32'({1'b1, e}));
                        chk($sformatf("i%0d stb_gap k=%0d", g, idx), since, CD);
                        last  = {e[24:3], 3'b000};
                        since = 0;
                        idx++;
                    end
                end else begin
                    chk($sformatf("i%0d hold", g), 32'(a), 32'({1'b0, last}));
                end
            end
        end

        task automatic drain(input int lim);
            for (int c = 0; c < lim && q.size() != 0; c++) begin
                @(negedge clk_in);
                #1;
            end
            if (q.size() != 0) begin
                chk($sformatf("i%0d drain_timeout", g), q.size(), 0);
                q.delete();
            end
        endtask

        initial begin
            rst = 1'b0;
            repeat (3) @(negedge clk_in);
            #1;
            rst = 1'b1;
            for (int k = 0; k < N1; k++) q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
            drain(N1 * CD + 10);
            rst = 1'b0;
            #1;
            chk($sformatf("i%0d async_reset", g), 32'(a), 32'({1'b0, RSTV}));
            repeat (2) @(negedge clk_in);
            #1;
            rst = 1'b1;
            for (int k = 0; k < N2; k++) q.push_back(model(k, HA, HF, HS, HB, VA, VF, VS, VB));
            drain(N2 * CD + 10);
            rst = 1'b0;
            n_done++;
        end
    end

    initial begin
        wait (n_done == 3);
        @(negedge clk_in);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got %0d finished instances expected 3", n_done);
        $fatal(1);
    end
endmodule
